// File: rtl/spi_readback_tx.sv
// spi_readback_tx: SPI mode-0 slave that returns a 16-bit readback word.
// Every input is resynchronized into the pck0 domain. A frame snapshots a
// response word (header, register select, optional sequence number, data)
// and shifts it out MSB first. It also captures 16 bits of mosi, which can
// select the register for the next readback.
// Optional feature: define SPI_READBACK_SEQ_EN to add a 4-bit frame
// sequence counter in response[11:8].
module spi_readback_tx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       pck0,
    input  logic       nreset,
    input  logic       spck,
    input  logic       ncs,
    input  logic       mosi,
    input  logic [7:0] conf_word,
    input  logic [7:0] divisor,
    input  logic [7:0] status,
    output logic       miso,
    output logic       frame_done,
    output logic       overrun
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DRAIN,
        WAIT_HIGH
    } state_t;

    // The synchronizers are flushed after SYNC_STAGES cycles; until then,
    // the ncs value only reflects the reset preset.
    localparam logic [1:0] SETTLE_DONE = 2'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0] spck_sync;
    logic [SYNC_STAGES-1:0] ncs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;

    logic        spck_s;
    logic        ncs_s;
    logic        mosi_s;
    logic        spck_d;
    logic        ncs_d;
    logic [1:0]  settle_cnt;

    logic        spck_rise;
    logic        spck_fall;
    logic        ncs_rise;
    logic        ncs_fall;

    state_t      state;
    logic [4:0]  bit_cnt;
    logic [1:0]  rd_sel;
    logic [15:0] shadow;
    logic [15:0] rx;
    logic [3:0]  seq_field;
    logic [7:0]  data_sel;
    logic [15:0] response;

`ifdef SPI_READBACK_SEQ_EN
    logic [3:0]  seq;
    assign seq_field = seq;
`else
    assign seq_field = 4'b0000;
`endif

    // Resynchronize the asynchronous SPI pins; ncs idles high, so its chain resets to 1.
    always_ff @(posedge pck0 or negedge nreset) begin
        if (!nreset) begin
            spck_sync <= '0;
            ncs_sync  <= '1;
            mosi_sync <= '0;
        end else begin
            spck_sync <= {spck_sync[SYNC_STAGES-2:0], spck};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
        end
    end

    assign spck_s = spck_sync[SYNC_STAGES-1];
    assign ncs_s  = ncs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Delay the synchronized pins by one cycle for edge detection, and count the flush cycles after reset.
    always_ff @(posedge pck0 or negedge nreset) begin
        if (!nreset) begin
            spck_d     <= 1'b0;
            ncs_d      <= 1'b1;
            settle_cnt <= 2'd0;
        end else begin
            spck_d <= spck_s;
            ncs_d  <= ncs_s;
            if (settle_cnt != SETTLE_DONE) begin
                settle_cnt <= settle_cnt + 2'd1;
            end
        end
    end

    assign spck_rise = spck_s & ~spck_d;
    assign spck_fall = ~spck_s & spck_d;
    assign ncs_rise  = ncs_s & ~ncs_d;
    assign ncs_fall  = ~ncs_s & ncs_d;

    // Select the readback data byte from the register chosen by the previous command.
    always_comb begin
        data_sel = 8'hA5;
        case (rd_sel)
            2'd0:    data_sel = conf_word;
            2'd1:    data_sel = divisor;
            2'd2:    data_sel = status;
            default: data_sel = 8'hA5;
        endcase
    end

    assign response = {2'b10, rd_sel, seq_field, data_sel};

    // Frame state machine: ncs edges take priority over spck edges in the same cycle.
    always_ff @(posedge pck0 or negedge nreset) begin
        if (!nreset) begin
            state      <= WAIT_HIGH;
            miso       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            bit_cnt    <= 5'd0;
            rd_sel     <= 2'd0;
            shadow     <= 16'h0000;
            rx         <= 16'h0000;
`ifdef SPI_READBACK_SEQ_EN
            seq        <= 4'd0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                WAIT_HIGH: begin
                    miso <= 1'b0;
                    if ((settle_cnt == SETTLE_DONE) && ncs_s) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    miso <= 1'b0;
                    if (ncs_fall) begin
                        shadow  <= response;
                        miso    <= response[15];
                        bit_cnt <= 5'd0;
                        overrun <= 1'b0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ncs_rise) begin
                        miso  <= 1'b0;
                        state <= IDLE;
                    end else if (spck_rise) begin
                        rx      <= {rx[14:0], mosi_s};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd15) begin
                            miso  <= 1'b0;
                            state <= DRAIN;
                        end
                    end else if (spck_fall) begin
                        // Rotating instead of zero-filling is harmless:
                        // the shadow register is reloaded every frame.
                        shadow <= {shadow[14:0], shadow[15]};
                        miso   <= shadow[14];
                    end
                end
                DRAIN: begin
                    miso <= 1'b0;
                    if (ncs_rise) begin
                        frame_done <= 1'b1;
                        if (rx[15:12] == 4'b0011) begin
                            rd_sel <= rx[1:0];
                        end
`ifdef SPI_READBACK_SEQ_EN
                        seq <= seq + 4'd1;
`endif
                        state <= IDLE;
                    end else if (spck_rise) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    miso  <= 1'b0;
                    state <= WAIT_HIGH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_readback_tx.sv
// Testbench for spi_readback_tx: table-driven readback frames plus
// hand-written sequences for short frames, overrun, reset mid-frame and
// sequence counter wrap (SPI_READBACK_SEQ_EN).
module tb_spi_readback_tx;

    logic       pck0;
    logic       nreset;
    logic       spck;
    logic       ncs;
    logic       mosi;
    logic [7:0] conf_word;
    logic [7:0] divisor;
    logic [7:0] status;
    logic       miso;
    logic       frame_done;
    logic       overrun;

    int         n_checks;
    int         n_pass;
    int         fd_count;
    int         exp_fd;
    logic [3:0] seq_model;

    typedef struct {
        logic [15:0] mosi_word;
        logic [7:0]  conf;
        logic [7:0]  div;
        logic [7:0]  stat;
        logic [15:0] exp_base;
    } vec_t;

    vec_t vecs[8];

    spi_readback_tx #(.SYNC_STAGES(2)) dut (
        .pck0       (pck0),
        .nreset     (nreset),
        .spck       (spck),
        .ncs        (ncs),
        .mosi       (mosi),
        .miso       (miso),
        .conf_word  (conf_word),
        .divisor    (divisor),
        .status     (status),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    // 100 MHz system clock.
    initial begin
        pck0 = 1'b0;
        forever #5 pck0 = ~pck0;
    end

    // Count frame_done pulses.
    always @(negedge pck0) begin
        if (frame_done) fd_count++;
    end

    function automatic logic [15:0] expWord(input logic [15:0] base);
        logic [3:0] fld;
`ifdef SPI_READBACK_SEQ_EN
        fld = seq_model;
`else
        fld = 4'h0;
`endif
        return base | {4'h0, fld, 8'h00};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
        end
    endtask

    // One SPI mode-0 frame. The master samples miso just before each rising edge.
    task automatic applyStimulus(input logic [15:0] tx, input int n_edges, output logic [31:0] cap);
        cap = '0;
        ncs = 1'b0;
        #100;
        for (int i = 0; i < n_edges; i++) begin
            mosi = (i < 16) ? tx[15-i] : 1'b0;
            #60;
            cap = {cap[30:0], miso};
            spck = 1'b1;
            #60;
            spck = 1'b0;
        end
        #60;
        ncs  = 1'b1;
        mosi = 1'b0;
        #100;
    endtask

    initial begin
        logic [31:0] cap;
        logic [15:0] exp_w;

        n_checks  = 0;
        n_pass    = 0;
        fd_count  = 0;
        exp_fd    = 0;
        seq_model = 4'h0;

        vecs[0] = '{16'h0000, 8'h41, 8'h7E, 8'h5C, 16'h8041};
        vecs[1] = '{16'h3002, 8'h41, 8'h7E, 8'h5C, 16'h8041};
        vecs[2] = '{16'h0000, 8'h41, 8'h7E, 8'h5C, 16'hA05C};
        vecs[3] = '{16'h3001, 8'h41, 8'h7E, 8'h33, 16'hA033};
        vecs[4] = '{16'h3003, 8'h41, 8'h7E, 8'h5C, 16'h907E};
        vecs[5] = '{16'h3000, 8'h41, 8'h7E, 8'h5C, 16'hB0A5};
        vecs[6] = '{16'h4002, 8'h41, 8'h7E, 8'h5C, 16'h8041};
        vecs[7] = '{16'h0000, 8'h0F, 8'h7E, 8'h5C, 16'h800F};

        nreset    = 1'b0;
        ncs       = 1'b1;
        spck      = 1'b0;
        mosi      = 1'b0;
        conf_word = 8'h41;
        divisor   = 8'h7E;
        status    = 8'h5C;
        #40;
        checkOutput("reset_miso", {31'b0, miso}, 32'd0);
        checkOutput("reset_frame_done", {31'b0, frame_done}, 32'd0);
        checkOutput("reset_overrun", {31'b0, overrun}, 32'd0);
        nreset = 1'b1;
        #100;

        // Table-driven full frames.
        for (int v = 0; v < 8; v++) begin
            conf_word = vecs[v].conf;
            divisor   = vecs[v].div;
            status    = vecs[v].stat;
            exp_w     = expWord(vecs[v].exp_base);
            applyStimulus(vecs[v].mosi_word, 16, cap);
            exp_fd++;
            seq_model++;
            checkOutput($sformatf("vec%0d_response", v), {16'h0, cap[15:0]}, {16'h0, exp_w});
            checkOutput($sformatf("vec%0d_frame_done", v), fd_count, exp_fd);
            checkOutput($sformatf("vec%0d_overrun", v), {31'b0, overrun}, 32'd0);
            checkOutput($sformatf("vec%0d_idle_miso", v), {31'b0, miso}, 32'd0);
        end

        // Short frame: 9 edges of a select command must be discarded.
        conf_word = 8'h41;
        exp_w = expWord(16'h8041);
        applyStimulus(16'h3003, 9, cap);
        checkOutput("short_bits", {23'h0, cap[8:0]}, {23'h0, exp_w[15:7]});
        checkOutput("short_no_frame_done", fd_count, exp_fd);
        exp_w = expWord(16'h8041);
        applyStimulus(16'h0000, 16, cap);
        exp_fd++;
        seq_model++;
        checkOutput("after_short_rd_sel", {16'h0, cap[15:0]}, {16'h0, exp_w});

        // Overrun: 18 spck edges in one frame.
        exp_w = expWord(16'h8041);
        applyStimulus(16'h0000, 18, cap);
        exp_fd++;
        seq_model++;
        checkOutput("overrun_response", {16'h0, cap[17:2]}, {16'h0, exp_w});
        checkOutput("overrun_tail_miso", {30'h0, cap[1:0]}, 32'd0);
        checkOutput("overrun_flag", {31'b0, overrun}, 32'd1);
        checkOutput("overrun_frame_done", fd_count, exp_fd);
        ncs = 1'b0;
        #100;
        checkOutput("overrun_cleared", {31'b0, overrun}, 32'd0);
        ncs = 1'b1;
        #100;
        checkOutput("empty_frame_no_done", fd_count, exp_fd);

        // Reset released while ncs is low: the frame in progress is ignored.
        cap = '0;
        ncs = 1'b0;
        #100;
        for (int i = 0; i < 4; i++) begin
            mosi = 1'b0;
            #60;
            spck = 1'b1;
            #60;
            spck = 1'b0;
        end
        nreset = 1'b0;
        #20;
        checkOutput("midreset_miso_in_reset", {31'b0, miso}, 32'd0);
        nreset = 1'b1;
        seq_model = 4'h0;
        for (int i = 4; i < 16; i++) begin
            mosi = exp_w[0] ^ exp_w[0] ^ ((16'h3003 >> (15 - i)) & 16'h1) != 16'h0;
            #60;
            cap = {cap[30:0], miso};
            spck = 1'b1;
            #60;
            spck = 1'b0;
        end
        #60;
        ncs  = 1'b1;
        mosi = 1'b0;
        #100;
        checkOutput("midreset_miso_zero", cap, 32'd0);
        checkOutput("midreset_no_frame_done", fd_count, exp_fd);
        exp_w = expWord(16'h8041);
        applyStimulus(16'h0000, 16, cap);
        exp_fd++;
        seq_model++;
        checkOutput("midreset_next_frame", {16'h0, cap[15:0]}, {16'h0, exp_w});
        checkOutput("midreset_next_done", fd_count, exp_fd);

        // Sequence field over 17+ frames (stays 0 when the counter is absent).
        exp_w = expWord(16'h8041);
        applyStimulus(16'h3003, 16, cap);
        exp_fd++;
        seq_model++;
        checkOutput("seq_select_frame", {16'h0, cap[15:0]}, {16'h0, exp_w});
        for (int f = 0; f < 17; f++) begin
            exp_w = expWord(16'hB0A5);
            applyStimulus(16'h3003, 16, cap);
            exp_fd++;
            seq_model++;
            checkOutput($sformatf("seq_frame%0d", f), {16'h0, cap[15:0]}, {16'h0, exp_w});
        end
        checkOutput("seq_total_frame_done", fd_count, exp_fd);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
